// File: rtl/stage_mem_pkg.sv
// -----------------------------------------------------------------------------
// stage_mem_pkg
// Shared RV32I types for the memory stage: opcode and funct3 encodings, the
// control word carried down the pipe, and the EX/MEM and MEM/WB register
// layouts.
// -----------------------------------------------------------------------------
package stage_mem_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lf_lb  = 3'b000,
        lf_lh  = 3'b001,
        lf_lw  = 3'b010,
        lf_lbu = 3'b100,
        lf_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sf_sb = 3'b000,
        sf_sh = 3'b001,
        sf_sw = 3'b010
    } store_funct3_t;

    // Arithmetic funct3 codes whose result is the comparator output.
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        load_regfile;
        logic [31:0] pc_plus4;
    } rv32i_control_word;

    typedef struct packed {
        logic              valid;
        rv32i_control_word ctrl;
        logic [31:0]       alu_out;
        logic              br_en;
        logic [31:0]       rs2;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        rv32i_control_word ctrl;
        logic [31:0]       data;
    } mem_wb_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_ACCESS
    } mem_state_t;

    // slt/sltu/slti/sltiu write the comparator bit rather than the ALU value.
    function automatic logic is_compare(input rv32i_control_word c);
        return ((c.opcode == op_reg) || (c.opcode == op_imm)) &&
               ((c.funct3 == F3_SLT) || (c.funct3 == F3_SLTU));
    endfunction

endpackage

// File: rtl/stage_mem_if.sv
// -----------------------------------------------------------------------------
// stage_mem_if
// Data-memory (d-cache) port between the memory stage and the cache.
//   read/write : request strobes, held until resp
//   addr       : word-aligned byte address
//   wdata      : lane-replicated store data
//   byte_en    : byte strobes for stores
//   resp       : one-cycle completion pulse
//   rdata      : load word, valid with resp
// -----------------------------------------------------------------------------
interface stage_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   byte_en;
    logic                  resp;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output read, write, addr, wdata, byte_en,
        input  resp, rdata
    );

    modport slave (
        input  read, write, addr, wdata, byte_en,
        output resp, rdata
    );
endinterface

// File: rtl/stage_mem_load_align.sv
// -----------------------------------------------------------------------------
// stage_mem_load_align
// Combinational load aligner: picks the addressed byte/half from a memory word
// and sign- or zero-extends it according to the load funct3.
//   funct3  : load funct3 (LB/LH/LW/LBU/LHU)
//   addr_lo : byte offset within the word
//   rdata   : raw memory word
//   data    : extended register value
// -----------------------------------------------------------------------------
module stage_mem_load_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (load_funct3_t'(funct3))
            lf_lb:   data = {{24{byte_sel[7]}}, byte_sel};
            lf_lbu:  data = {24'b0, byte_sel};
            lf_lh:   data = {{16{half_sel[15]}}, half_sel};
            lf_lhu:  data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem
// Memory stage of the 5-stage RV32I pipeline: EX/MEM register, d-cache request
// with stall handshake, load alignment, MEM->EX forwarding and MEM/WB register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ex_*            : instruction leaving EX (valid, control, ALU, compare, rs2)
//   flush           : kill the instruction entering EX/MEM
//   dmem            : d-cache port (master side)
//   mem_stall       : freeze PC/IF/ID/EX while a memory access is outstanding
//   mem_to_ex_fwd   : non-load result of the EX/MEM instruction
//   mem_rd          : destination of the EX/MEM instruction, 0 if none
//   wb_valid/ctrl/data : MEM/WB register contents for writeback
// -----------------------------------------------------------------------------
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  rv32i_control_word ex_ctrl,
    input  logic [ADDR_W-1:0] ex_alu_out,
    input  logic              ex_br_en,
    input  logic [DATA_W-1:0] ex_rs2,
    input  logic              flush,
    stage_mem_if.master       dmem,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_to_ex_fwd,
    output logic [4:0]        mem_rd,
    output logic              wb_valid,
    output rv32i_control_word wb_ctrl,
    output logic [DATA_W-1:0] wb_data
);
    ex_mem_t    exm_q, exm_d;
    mem_wb_t    wb_q, wb_d;
    logic       done_q, done_d;
    mem_state_t state;
    logic       is_load, is_store, access;
    logic [1:0] a;
    logic [31:0] load_word, nonload_val;

    assign a = exm_q.alu_out[1:0];

    stage_mem_load_align u_load_align (
        .funct3  (exm_q.ctrl.funct3),
        .addr_lo (a),
        .rdata   (dmem.rdata),
        .data    (load_word)
    );

    // Access state and request strobes. The request is combinational so an
    // async reset drops it the instant the EX/MEM register clears.
    always_comb begin
        is_load   = exm_q.valid && (exm_q.ctrl.opcode == op_load);
        is_store  = exm_q.valid && (exm_q.ctrl.opcode == op_store);
        state     = ((is_load || is_store) && !done_q) ? MEM_ACCESS : MEM_IDLE;
        access    = (state == MEM_ACCESS);
        mem_stall = access && !dmem.resp;
        dmem.read  = access && is_load;
        dmem.write = access && is_store;
        dmem.addr  = {exm_q.alu_out[31:2], 2'b00};
    end

    // Store lane steering; misaligned low bits are dropped, never trapped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dmem.byte_en = 4'b0000;
        dmem.wdata   = exm_q.rs2;
        if (is_store) begin
            case (store_funct3_t'(exm_q.ctrl.funct3))
                sf_sb: begin
                    dmem.byte_en = 4'b0001 << a;
                    dmem.wdata   = {4{exm_q.rs2[7:0]}};
                end
                sf_sh: begin
                    dmem.byte_en = 4'b0011 << {a[1], 1'b0};
                    dmem.wdata   = {2{exm_q.rs2[15:0]}};
                end
                default: dmem.byte_en = 4'b1111;
            endcase
        end
    end

    // Result mux for everything except loads; this is also the forward value.
    always_comb begin
        if ((exm_q.ctrl.opcode == op_jal) || (exm_q.ctrl.opcode == op_jalr))
            nonload_val = exm_q.ctrl.pc_plus4;
        else if (is_compare(exm_q.ctrl))
            nonload_val = {31'b0, exm_q.br_en};
        else
            nonload_val = exm_q.alu_out;
    end

    assign mem_to_ex_fwd = nonload_val;
    assign mem_rd = (exm_q.valid && exm_q.ctrl.load_regfile) ? exm_q.ctrl.rd : 5'd0;

    // Next-state for the pipeline registers.
    always_comb begin
        exm_d = exm_q;
        wb_d  = '0;
        if (!mem_stall) begin
            if (flush || !ex_valid) begin
                exm_d = '0;
            end else begin
                exm_d.valid   = 1'b1;
                exm_d.ctrl    = ex_ctrl;
                exm_d.alu_out = ex_alu_out;
                exm_d.br_en   = ex_br_en;
                exm_d.rs2     = ex_rs2;
            end
            wb_d.valid = exm_q.valid;
            wb_d.ctrl  = exm_q.ctrl;
            wb_d.data  = is_load ? load_word : nonload_val;
        end
        // resp always lets the stage advance today, so done only holds across
        // an edge if another stall source is added later.
        done_d = mem_stall ? (done_q || (access && dmem.resp)) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_q  <= '0;
            wb_q   <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            exm_q  <= exm_d;
            wb_q   <= wb_d;
            done_q <= done_d;
        end
    end

    assign wb_valid = wb_q.valid;
    assign wb_ctrl  = wb_q.ctrl;
    assign wb_data  = wb_q.data;
endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_mem
// Directed bench for stage_mem with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    rv32i_control_word ex_ctrl;
    logic [31:0]       ex_alu_out;
    logic              ex_br_en;
    logic [31:0]       ex_rs2;
    logic              flush;
    logic              mem_stall;
    logic [31:0]       mem_to_ex_fwd;
    logic [4:0]        mem_rd;
    logic              wb_valid;
    rv32i_control_word wb_ctrl;
    logic [31:0]       wb_data;

    int n_checks = 0;
    int n_errors = 0;

    stage_mem_if dmem_if ();

    stage_mem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ctrl       (ex_ctrl),
        .ex_alu_out    (ex_alu_out),
        .ex_br_en      (ex_br_en),
        .ex_rs2        (ex_rs2),
        .flush         (flush),
        .dmem          (dmem_if),
        .mem_stall     (mem_stall),
        .mem_to_ex_fwd (mem_to_ex_fwd),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_ctrl       (wb_ctrl),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word mk(input rv32i_opcode op, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic lr,
                                             input logic [31:0] pc4);
        rv32i_control_word c;
        c.opcode       = op;
        c.funct3       = f3;
        c.rd           = rd;
        c.load_regfile = lr;
        c.pc_plus4     = pc4;
        return c;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input rv32i_control_word c, input logic [31:0] alu,
                           input logic [31:0] rs2, input logic br);
        ex_valid   = 1'b1;
        ex_ctrl    = c;
        ex_alu_out = alu;
        ex_rs2     = rs2;
        ex_br_en   = br;
    endtask

    task automatic bubble();
        ex_valid   = 1'b0;
        ex_ctrl    = '0;
        ex_alu_out = '0;
        ex_rs2     = '0;
        ex_br_en   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        dmem_if.resp  = 1'b0;
        dmem_if.rdata = '0;
        bubble();
        #3;
        check("rst_read",     dmem_if.read,  0);
        check("rst_write",    dmem_if.write, 0);
        check("rst_stall",    mem_stall,     0);
        check("rst_wb_valid", wb_valid,      0);
        check("rst_mem_rd",   mem_rd,        0);
        #9 rst_n = 1'b1;
        tick();

        // ADD, no memory op; a stray resp must be ignored.
        present(mk(op_reg, 3'b000, 5'd1, 1'b1, 32'h0), 32'h10, 32'h0, 1'b0);
        tick();
        bubble();
        check("add_fwd",    mem_to_ex_fwd, 32'h10);
        check("add_mem_rd", mem_rd,        5'd1);
        check("add_stall",  mem_stall,     0);
        check("add_read",   dmem_if.read,  0);
        dmem_if.resp = 1'b1;
        #1;
        check("stray_resp_stall", mem_stall, 0);
        dmem_if.resp = 1'b0;
        tick();
        check("add_wb_valid", wb_valid,   1);
        check("add_wb_data",  wb_data,    32'h10);
        check("add_wb_rd",    wb_ctrl.rd, 5'd1);

        // SB 0xAB at 0x1003, resp one cycle late.
        present(mk(op_store, 3'b000, 5'd0, 1'b0, 32'h0), 32'h1003, 32'h0000_00AB, 1'b0);
        tick();
        bubble();
        check("sb_addr",    dmem_if.addr,    32'h1000);
        check("sb_byte_en", dmem_if.byte_en, 4'b1000);
        check("sb_wdata",   dmem_if.wdata,   32'hABAB_ABAB);
        check("sb_write",   dmem_if.write,   1);
        check("sb_read",    dmem_if.read,    0);
        check("sb_stall",   mem_stall,       1);
        tick();
        check("sb_write_held", dmem_if.write, 1);
        check("sb_stall_held", mem_stall,     1);
        dmem_if.resp = 1'b1;
        #1;
        check("sb_resp_stall", mem_stall, 0);
        tick();
        dmem_if.resp = 1'b0;
        check("sb_write_done", dmem_if.write, 0);
        check("sb_wb_valid",   wb_valid,      1);

        // LH at 0x2002, three stall cycles, then resp.
        present(mk(op_load, 3'b001, 5'd3, 1'b1, 32'h0), 32'h2002, 32'h0, 1'b0);
        tick();
        bubble();
        dmem_if.rdata = 32'h8001_1234;
        check("lh_mem_rd", mem_rd, 5'd3);
        for (int i = 0; i < 3; i++) begin
            check("lh_stall",    mem_stall,    1);
            check("lh_read",     dmem_if.read, 1);
            check("lh_wb_quiet", wb_valid,     0);
            tick();
        end
        dmem_if.resp = 1'b1;
        #1;
        check("lh_resp_stall", mem_stall, 0);
        tick();
        dmem_if.resp = 1'b0;
        check("lh_wb_valid", wb_valid,   1);
        check("lh_wb_data",  wb_data,    32'hFFFF_8001);
        check("lh_wb_rd",    wb_ctrl.rd, 5'd3);
        tick();
        check("lh_single_pulse", wb_valid, 0);

        // LHU, resp in the same cycle.
        present(mk(op_load, 3'b101, 5'd4, 1'b1, 32'h0), 32'h2002, 32'h0, 1'b0);
        tick();
        bubble();
        dmem_if.resp = 1'b1;
        #1;
        check("lhu_stall", mem_stall,    0);
        check("lhu_read",  dmem_if.read, 1);
        tick();
        dmem_if.resp = 1'b0;
        check("lhu_wb_data", wb_data, 32'h0000_8001);

        // LB at 0x3001: byte 1 of 0x00008000 is 0x80.
        present(mk(op_load, 3'b000, 5'd2, 1'b1, 32'h0), 32'h3001, 32'h0, 1'b0);
        tick();
        bubble();
        dmem_if.rdata = 32'h0000_8000;
        dmem_if.resp  = 1'b1;
        tick();
        dmem_if.resp = 1'b0;
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);

        // SH at 0x1006 -> upper half lanes.
        present(mk(op_store, 3'b001, 5'd0, 1'b0, 32'h0), 32'h1006, 32'h1234_BEEF, 1'b0);
        tick();
        bubble();
        check("sh_addr",    dmem_if.addr,    32'h1004);
        check("sh_byte_en", dmem_if.byte_en, 4'b1100);
        check("sh_wdata",   dmem_if.wdata,   32'hBEEF_BEEF);
        dmem_if.resp = 1'b1;
        tick();
        dmem_if.resp = 1'b0;

        // SW at misaligned 0x100B -> low bits dropped.
        present(mk(op_store, 3'b010, 5'd0, 1'b0, 32'h0), 32'h100B, 32'hDEAD_BEEF, 1'b0);
        tick();
        bubble();
        check("sw_addr",    dmem_if.addr,    32'h1008);
        check("sw_byte_en", dmem_if.byte_en, 4'b1111);
        check("sw_wdata",   dmem_if.wdata,   32'hDEAD_BEEF);
        dmem_if.resp = 1'b1;
        tick();
        dmem_if.resp = 1'b0;

        // SLT with br_en=1, ALU value must not leak through.
        present(mk(op_reg, 3'b010, 5'd7, 1'b1, 32'h0), 32'h0000_DEAD, 32'h0, 1'b1);
        tick();
        bubble();
        check("slt_fwd", mem_to_ex_fwd, 32'h1);
        tick();
        check("slt_wb_data", wb_data, 32'h1);

        // JAL returns pc_plus4.
        present(mk(op_jal, 3'b000, 5'd1, 1'b1, 32'h104), 32'h2000, 32'h0, 1'b0);
        tick();
        bubble();
        check("jal_fwd", mem_to_ex_fwd, 32'h104);
        tick();
        check("jal_wb_data", wb_data, 32'h104);

        // Flush during a 2-cycle LW stall: load completes, follower is killed.
        present(mk(op_load, 3'b010, 5'd5, 1'b1, 32'h0), 32'h4000, 32'h0, 1'b0);
        tick();
        present(mk(op_reg, 3'b000, 5'd6, 1'b1, 32'h0), 32'h77, 32'h0, 1'b0);
        flush         = 1'b1;
        dmem_if.rdata = 32'hCAFE_BABE;
        check("fl_stall1", mem_stall, 1);
        tick();
        check("fl_stall2", mem_stall, 1);
        check("fl_mem_rd", mem_rd,    5'd5);
        tick();
        dmem_if.resp = 1'b1;
        #1;
        check("fl_resp_stall", mem_stall, 0);
        tick();
        dmem_if.resp = 1'b0;
        flush        = 1'b0;
        bubble();
        check("fl_wb_valid", wb_valid, 1);
        check("fl_wb_data",  wb_data,  32'hCAFE_BABE);
        check("fl_killed_rd", mem_rd,  5'd0);
        tick();
        check("fl_killed_wb", wb_valid, 0);

        // Async reset while a load request is outstanding.
        present(mk(op_reg, 3'b000, 5'd8, 1'b1, 32'h0), 32'h99, 32'h0, 1'b0);
        tick();
        present(mk(op_load, 3'b010, 5'd9, 1'b1, 32'h0), 32'h5000, 32'h0, 1'b0);
        tick();
        bubble();
        check("pre_rst_read",     dmem_if.read, 1);
        check("pre_rst_wb_valid", wb_valid,     1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_read",     dmem_if.read, 0);
        check("arst_wb_valid", wb_valid,     0);
        check("arst_stall",    mem_stall,    0);
        check("arst_mem_rd",   mem_rd,       0);
        #2 rst_n = 1'b1;
        present(mk(op_reg, 3'b000, 5'd10, 1'b1, 32'h0), 32'h55, 32'h0, 1'b0);
        tick();
        bubble();
        check("post_rst_fwd",    mem_to_ex_fwd, 32'h55);
        check("post_rst_mem_rd", mem_rd,        5'd10);
        tick();
        check("post_rst_wb_valid", wb_valid, 1);
        check("post_rst_wb_data",  wb_data,  32'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
